// File: rtl/alu_multiciclo.sv
// alu_multiciclo: registered multicycle ALU for the execute stage.
// Single-cycle ops (logic, add/sub, compares) finish at the accepting edge.
// MUL/MULHU use a shift-add multiplier and DIVU/REMU a restoring divider.
// Both run one step per cycle for WIDTH cycles, then spend a FIN cycle writing the result.
// The divider is only built when the ALU_DIV_EN macro is defined.
// Without it, 1010/1011 behave as unused opcodes (single-cycle, result 0).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      request; sampled only while busy=0
//   Ope1/Ope2  operands, captured on an accepted start
//   AluOp      4-bit operation select, captured on an accepted start
//   Resultado  registered result; holds until the next done
//   zero       registered Resultado==0
//   overflow   registered signed overflow of ADD/SUB
//   div0       registered divide-by-zero flag for DIVU/REMU
//   busy       multicycle operation in progress
//   done       one-cycle pulse; result outputs valid
module alu_multiciclo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] Ope1,
  input  logic [WIDTH-1:0] Ope2,
  input  logic [3:0]       AluOp,
  output logic [WIDTH-1:0] Resultado,
  output logic             zero,
  output logic             overflow,
  output logic             div0,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef ALU_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_FIN  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opb;
  logic             hi_sel, div0_pend;

  logic [WIDTH-1:0] sum, diff, alu_res, fin_res;
  logic             alu_ovf, start_mul, start_div, last_step;
  logic [WIDTH:0]   mul_sum;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
`endif

  // Single-cycle datapath
  always_comb begin
    sum     = Ope1 + Ope2;
    diff    = Ope1 - Ope2;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (AluOp)
      4'b0000: alu_res = Ope1 & Ope2;
      4'b0001: alu_res = Ope1 | Ope2;
      4'b0010: begin
        alu_res = sum;
        alu_ovf = (Ope1[WIDTH-1] == Ope2[WIDTH-1]) && (sum[WIDTH-1] != Ope1[WIDTH-1]);
      end
      4'b0011: alu_res = Ope1 ^ Ope2;
      4'b0100: alu_res = ~(Ope1 | Ope2);
      4'b0101: alu_res = {{(WIDTH-1){1'b0}}, (Ope1 < Ope2)};
      4'b0110: begin
        alu_res = diff;
        alu_ovf = (Ope1[WIDTH-1] != Ope2[WIDTH-1]) && (diff[WIDTH-1] != Ope1[WIDTH-1]);
      end
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(Ope1) < $signed(Ope2))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    start_mul = start && (AluOp[3:1] == 3'b100);
`ifdef ALU_DIV_EN
    start_div = start && (AluOp[3:1] == 3'b101);
`else
    start_div = 1'b0;
`endif
    last_step = (cnt == CW'(WIDTH - 1));
    // The MULHU/REMU result sits in acc_hi and the MUL/DIVU result in acc_lo.
    // AluOp[0] picks between them.
    fin_res   = hi_sel ? acc_hi : acc_lo;
    // Shift-add step: conditionally add B to the high half, then shift the whole product right.
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  end

`ifdef ALU_DIV_EN
  // Restoring step: the partial remainder shifts in the next dividend bit.
  // A missing borrow means the trial subtraction fits.
  // Divisor 0 yields all-ones quotient and remainder = dividend.
  always_comb begin
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    div_ge    = ~div_diff[WIDTH];
  end
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start_mul) state_next = S_MUL;
`ifdef ALU_DIV_EN
        else if (start_div) state_next = S_DIV;
`endif
      end
      S_MUL:   if (last_step) state_next = S_FIN;
`ifdef ALU_DIV_EN
      S_DIV:   if (last_step) state_next = S_FIN;
`endif
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Resultado <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
      div0      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opb       <= '0;
      hi_sel    <= 1'b0;
      div0_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_mul || start_div) begin
            acc_hi    <= '0;
            acc_lo    <= Ope1;
            opb       <= Ope2;
            hi_sel    <= AluOp[0];
            cnt       <= '0;
            div0_pend <= start_div && (Ope2 == '0);
          end else if (start) begin
            Resultado <= alu_res;
            zero      <= (alu_res == '0);
            overflow  <= alu_ovf;
            div0      <= 1'b0;
            done      <= 1'b1;
          end
        end
        S_MUL: begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          cnt <= last_step ? '0 : cnt + 1'b1;
        end
`ifdef ALU_DIV_EN
        S_DIV: begin
          acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          cnt    <= last_step ? '0 : cnt + 1'b1;
        end
`endif
        S_FIN: begin
          Resultado <= fin_res;
          zero      <= (fin_res == '0);
          overflow  <= 1'b0;
          div0      <= div0_pend;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Scoreboard bench for alu_multiciclo (WIDTH=32); honours ALU_DIV_EN.
module tb_alu_multiciclo;
  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [W-1:0]  Ope1, Ope2;
  logic [3:0]    AluOp;
  logic [W-1:0]  Resultado;
  logic          zero, overflow, div0, busy, done;

  always #5 clk = ~clk;

  alu_multiciclo #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .Ope1(Ope1), .Ope2(Ope2),
    .AluOp(AluOp), .Resultado(Resultado), .zero(zero), .overflow(overflow),
    .div0(div0), .busy(busy), .done(done)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] res;
    logic         ov;
    logic         d0;
    int unsigned  due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model built on 64-bit arithmetic
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic ov, output logic d0,
                                output logic multi);
    logic [63:0] p;
    longint sa, sbv, s;
    r = '0; ov = 1'b0; d0 = 1'b0; multi = 1'b0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    p   = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin r = a + b; s = sa + sbv; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd3: r = a ^ b;
      4'd4: r = ~(a | b);
      4'd5: r = (a < b) ? 32'd1 : 32'd0;
      4'd6: begin r = a - b; s = sa - sbv; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd7: r = (sa < sbv) ? 32'd1 : 32'd0;
      4'd8: begin r = p[31:0];  multi = 1'b1; end
      4'd9: begin r = p[63:32]; multi = 1'b1; end
`ifdef ALU_DIV_EN
      4'd10: begin multi = 1'b1; d0 = (b == 0); r = (b == 0) ? 32'hFFFF_FFFF : a / b; end
      4'd11: begin multi = 1'b1; d0 = (b == 0); r = (b == 0) ? a : a % b; end
`endif
      default: r = '0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] r;
    logic ov, d0, mu;
    int k;
    @(negedge clk);
    k = 0;
    while (busy && k < 200) begin @(negedge clk); k++; end
    if (busy) begin
      check("issue_timeout", 1, 0);
      return;
    end
    Ope1 = a; Ope2 = b; AluOp = op; start = 1'b1;
    model(op, a, b, r, ov, d0, mu);
    e.op = op; e.res = r; e.ov = ov; e.d0 = d0;
    e.due = cyc + 1 + (mu ? W + 1 : 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    Ope1 = $urandom; Ope2 = $urandom; AluOp = 4'($urandom);
  endtask

  // Output monitor
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("res_op%0d", mon_e.op), Resultado, mon_e.res);
        check($sformatf("zero_op%0d", mon_e.op), zero, (mon_e.res == 0));
        check($sformatf("ovf_op%0d", mon_e.op), overflow, mon_e.ov);
        check($sformatf("div0_op%0d", mon_e.op), div0, mon_e.d0);
        check($sformatf("latency_op%0d", mon_e.op), cyc, mon_e.due);
      end
    end
  end

  initial begin
    int bcnt, k;
    reset = 1'b1; start = 1'b0; Ope1 = '0; Ope2 = '0; AluOp = '0;
    repeat (2) @(negedge clk);
    check("rst_res", Resultado, 0);
    check("rst_zero", zero, 1);
    check("rst_ovf", overflow, 0);
    check("rst_div0", div0, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    // Reset in the middle of a multiply
    @(negedge clk);
    Ope1 = 7; Ope2 = 9; AluOp = 4'd8; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_res", Resultado, 0);
    check("midrst_zero", zero, 1);
    check("midrst_ovf", overflow, 0);
    check("midrst_div0", div0, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk) reset = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_idle", busy, 0);

    issue(4'd8, 7, 9);
    issue(4'd0, 32'hF0F0_1234, 32'h0FF0_FF00);
    issue(4'd1, 32'hF000_0001, 32'h0000_1230);
    issue(4'd3, 32'hAAAA_5555, 32'hFFFF_0000);
    issue(4'd4, 32'h1234_0000, 32'h0000_5678);
    issue(4'd2, 32'h7FFF_FFFF, 32'h1);
    issue(4'd6, 5, 5);
    issue(4'd6, 32'h8000_0000, 32'h1);
    issue(4'd2, 32'h8000_0000, 32'h8000_0000);
    issue(4'd7, 32'hFFFF_FFFF, 32'h1);
    issue(4'd5, 32'hFFFF_FFFF, 32'h1);

    // MULHU with busy length and an ignored mid-operation start
    issue(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bcnt = 0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      bcnt++;
      if (k == 4) begin
        start = 1'b1; AluOp = 4'd2; Ope1 = 1; Ope2 = 1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("busy_cycles", bcnt, 33);

    // Back-to-back: ADD issued in the done cycle of a MUL
    issue(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(4'd2, 1, 2);

    issue(4'd10, 100, 7);
    issue(4'd11, 100, 7);
    issue(4'd10, 5, 0);
    issue(4'd11, 5, 0);
    for (int i = 12; i < 16; i++) issue(4'(i), 32'hDEAD_BEEF, 32'h1234_5678);

    for (int i = 0; i < 24; i++)
      issue(4'($urandom_range(0, 15)), $urandom, (i % 5 == 0) ? 32'h0 : $urandom);

    k = 0;
    while (sb.size() != 0 && k < 200) begin @(negedge clk); k++; end
    check("drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
